// File: rtl/fp_pkg.sv
// Shared definitions for the 24-bit fp word {sign, m[14:0], e[7:0]}.
// Holds field widths, exponent limits, the word layout and the divider state enum.
package fp_pkg;

  localparam int FP_W   = 24;
  localparam int MANT_W = 15;
  localparam int EXP_W  = 8;
  localparam int XEXP_W = 10;

  localparam logic [MANT_W-1:0]        FP_ONE   = 15'h4000;
  localparam logic [MANT_W-1:0]        MANT_MAX = 15'h7FFF;
  localparam logic signed [XEXP_W-1:0] EXP_MAX  = 10'sd127;
  localparam logic signed [XEXP_W-1:0] EXP_MIN  = -10'sd128;

  typedef struct packed {
    logic              sign;
    logic [MANT_W-1:0] m;
    logic [EXP_W-1:0]  e;
  } fp_word_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DIV,
    PACK,
    DONE
  } div_state_t;

  // Negative words store the two's complement of the magnitude within the 15-bit field.
  function automatic logic [MANT_W-1:0] fp_encode_mant(input logic sign,
                                                       input logic [MANT_W-1:0] mag);
    return sign ? (~mag + 15'd1) : mag;
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// Combinational decode of an fp word into sign, 15-bit magnitude and 10-bit signed exponent.
// A negative word with m==0 stands for magnitude FP_ONE one binade higher.
module fp_unpack
  import fp_pkg::*;
(
  input  logic [FP_W-1:0]          word,
  output logic                     sign,
  output logic [MANT_W-1:0]        mag,
  output logic signed [XEXP_W-1:0] expo
);

  fp_word_t w;

  assign w = word;

  always_comb begin
    sign = w.sign;
    mag  = w.m;
    expo = {{(XEXP_W-EXP_W){w.e[EXP_W-1]}}, w.e};
    if (w.sign) begin
      if (w.m == '0) begin
        mag  = FP_ONE;
        expo = expo + 10'sd1;
      end else begin
        mag = ~w.m + 15'd1;
      end
    end
  end

endmodule

// File: rtl/fp_div.sv
// Iterative restoring divider for fp words, one quotient bit per cycle, valid/ready on both sides.
// Define FP_DIV_ROUND_EN to round the quotient half-up on the guard bit; otherwise it truncates.
module fp_div
  import fp_pkg::*;
#(
  parameter int QBITS = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FP_W-1:0] o,
  output logic            valid,
  output logic            over_flow,
  output logic            under_flow,
  output logic            div_by_zero
);

`ifdef FP_DIV_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  localparam int CNT_W = $clog2(QBITS);
  localparam logic [CNT_W-1:0] DIV_STEPS = CNT_W'(QBITS - 2);

  div_state_t state, state_next;

  logic [FP_W-1:0]          a_q, b_q;
  logic                     sa, sb;
  logic [MANT_W-1:0]        ma, mb;
  logic signed [XEXP_W-1:0] ea, eb;
  logic                     a_zero, b_zero, a_lt_b;

  logic [MANT_W+1:0] rem, rem_init, step_in, step_diff, step_out;
  logic [MANT_W-1:0] divisor, step_div;
  logic              step_bit;
  logic [QBITS-1:0]  quot;
  logic [CNT_W-1:0]  cnt;
  logic              sq;
  logic signed [XEXP_W-1:0] eq;

  logic [MANT_W-1:0]        q_mag, pack_mag;
  logic [MANT_W:0]          q_sum;
  logic signed [XEXP_W-1:0] pack_exp;
  logic                     pack_ovf, pack_unf, pack_dbz, pack_valid;
  logic [FP_W-1:0]          pack_word;

  fp_unpack u_unpack_a (.word(a_q), .sign(sa), .mag(ma), .expo(ea));
  fp_unpack u_unpack_b (.word(b_q), .sign(sb), .mag(mb), .expo(eb));

  assign a_zero = (a_q == '0);
  assign b_zero = (b_q == '0);
  assign a_lt_b = (ma < mb);

  // Aligning the dividend into [Mb, 2*Mb) makes the leading quotient bit always 1, so LOAD resolves it.
  always_comb begin
    rem_init  = a_lt_b ? {1'b0, ma, 1'b0} : {2'b00, ma};
    step_in   = (state == LOAD) ? rem_init : rem;
    step_div  = (state == LOAD) ? mb : divisor;
    step_bit  = (step_in >= {2'b00, step_div});
    step_diff = step_in - {2'b00, step_div};
    step_out  = (step_bit ? step_diff : step_in) << 1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = LOAD;
      LOAD: state_next = (a_zero || b_zero) ? PACK : DIV;
      DIV:  if (cnt == '0) state_next = PACK;
      PACK: state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // A rounding carry out of the magnitude renormalises before the exponent range check.
  always_comb begin
    q_mag    = quot[QBITS-1 -: MANT_W];
    q_sum    = {1'b0, q_mag} + (MANT_W+1)'(ROUND_EN & quot[0]);
    pack_mag = q_sum[MANT_W-1:0];
    pack_exp = eq;
    if (q_sum[MANT_W]) begin
      pack_mag = FP_ONE;
      pack_exp = eq + 10'sd1;
    end
    pack_ovf   = (pack_exp > EXP_MAX);
    pack_unf   = (pack_exp < EXP_MIN);
    pack_dbz   = 1'b0;
    pack_valid = 1'b1;
    pack_word  = {sq, fp_encode_mant(sq, pack_mag), pack_exp[EXP_W-1:0]};
    if (b_zero) begin
      pack_dbz   = 1'b1;
      pack_ovf   = 1'b0;
      pack_unf   = 1'b0;
      pack_valid = 1'b0;
      pack_word  = {sa, MANT_MAX, EXP_MAX[EXP_W-1:0]};
    end else if (a_zero) begin
      pack_ovf  = 1'b0;
      pack_unf  = 1'b0;
      pack_word = '0;
    end else if (pack_ovf) begin
      pack_valid = 1'b0;
      pack_word  = {sq, fp_encode_mant(sq, MANT_MAX), EXP_MAX[EXP_W-1:0]};
    end else if (pack_unf) begin
      pack_valid = 1'b0;
      pack_word  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      rem         <= '0;
      divisor     <= '0;
      quot        <= '0;
      cnt         <= '0;
      sq          <= 1'b0;
      eq          <= '0;
      o           <= '0;
      valid       <= 1'b0;
      over_flow   <= 1'b0;
      under_flow  <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q <= a;
            b_q <= b;
          end
        end
        LOAD: begin
          divisor <= mb;
          sq      <= sa ^ sb;
          eq      <= a_lt_b ? (ea - eb - 10'sd1) : (ea - eb);
          rem     <= step_out;
          quot    <= {{(QBITS-1){1'b0}}, step_bit};
          cnt     <= DIV_STEPS;
        end
        DIV: begin
          rem  <= step_out;
          quot <= {quot[QBITS-2:0], step_bit};
          cnt  <= cnt - 1'b1;
        end
        PACK: begin
          o           <= pack_word;
          valid       <= pack_valid;
          over_flow   <= pack_ovf;
          under_flow  <= pack_unf;
          div_by_zero <= pack_dbz;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div.sv
// Directed bench for fp_div: hand-computed quotients, range and zero cases, handshake and reset.
// Expected values for the rounding vector follow FP_DIV_ROUND_EN.
module tb_fp_div;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] o;
  logic        valid, over_flow, under_flow, div_by_zero;

  int compare_count = 0;
  int fail_count    = 0;

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic [23:0] o;
    logic [3:0]  flags;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  always #5 clk = ~clk;

  fp_div dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .o(o),
    .valid(valid), .over_flow(over_flow), .under_flow(under_flow),
    .div_by_zero(div_by_zero)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compare_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Entered at a negedge with the divider idle; returns the cycle out_valid first shows.
  task automatic applyStimulus(input logic [23:0] ta, input logic [23:0] tb, output int lat);
    checkOutput("acc_ready", {31'd0, in_ready}, 32'd1);
    a        = ta;
    b        = tb;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int lat, first_acc, second_acc, cyc;
    logic saw_valid;

    vecs[0]  = '{24'h400000, 24'h400000, 24'h400000, 4'b1000, 18};
    vecs[1]  = '{24'h400000, 24'h600000, 24'h5555FF, 4'b1000, 18};
    vecs[2]  = '{24'h8000FF, 24'h400000, 24'hC00000, 4'b1000, 18};
    vecs[3]  = '{24'hC00000, 24'hC00000, 24'h400000, 4'b1000, 18};
    vecs[4]  = '{24'h400000, 24'hC00000, 24'hC00000, 4'b1000, 18};
    vecs[5]  = '{24'h400000, 24'hA00000, 24'hAAABFF, 4'b1000, 18};
`ifdef FP_DIV_ROUND_EN
    vecs[6]  = '{24'h400000, 24'h700000, 24'h4925FF, 4'b1000, 18};
`else
    vecs[6]  = '{24'h400000, 24'h700000, 24'h4924FF, 4'b1000, 18};
`endif
    vecs[7]  = '{24'h40007F, 24'h400000, 24'h40007F, 4'b1000, 18};
    vecs[8]  = '{24'h40007F, 24'h4000FF, 24'h7FFF7F, 4'b0100, 18};
    vecs[9]  = '{24'h40007F, 24'h400080, 24'h7FFF7F, 4'b0100, 18};
    vecs[10] = '{24'h400080, 24'h400000, 24'h400080, 4'b1000, 18};
    vecs[11] = '{24'h400080, 24'h600000, 24'h000000, 4'b0010, 18};
    vecs[12] = '{24'h400000, 24'h000000, 24'h7FFF7F, 4'b0001, 3};
    vecs[13] = '{24'h000000, 24'h000000, 24'h7FFF7F, 4'b0001, 3};
    vecs[14] = '{24'h000000, 24'h400000, 24'h000000, 4'b1000, 3};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_o", {8'd0, o}, 32'd0);
    checkOutput("rst_flags", {28'd0, valid, over_flow, under_flow, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, lat);
      checkOutput($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      checkOutput($sformatf("v%0d_o", i), {8'd0, o}, {8'd0, vecs[i].o});
      checkOutput($sformatf("v%0d_flags", i),
                  {28'd0, valid, over_flow, under_flow, div_by_zero}, {28'd0, vecs[i].flags});
      handoff();
    end

    // Result must hold while the consumer stalls.
    applyStimulus(24'h400000, 24'h600000, lat);
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_o", {8'd0, o}, 32'h005555FF);
      checkOutput("hold_in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("hold_out_valid", {31'd0, out_valid}, 32'd1);
      @(negedge clk);
    end
    handoff();

    a          = 24'h400000;
    b          = 24'h400000;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    first_acc  = -1;
    second_acc = -1;
    for (int t = 0; t < 80 && second_acc < 0; t++) begin
      if (in_ready) begin
        if (first_acc < 0) first_acc = t;
        else second_acc = t;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput("b2b_period", second_acc - first_acc, 32'd19);
    repeat (25) @(negedge clk);
    out_ready = 1'b0;
    checkOutput("b2b_o", {8'd0, o}, 32'h00400000);
    checkOutput("b2b_idle", {31'd0, in_ready}, 32'd1);

    // Abandon a divide at cycle 8; o currently holds a nonzero earlier result.
    a        = 24'h400000;
    b        = 24'h600000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cyc      = 1;
    while (cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("mid_rst_o", {8'd0, o}, 32'd0);
    rst_n     = 1'b1;
    saw_valid = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    checkOutput("no_stale", {31'd0, saw_valid}, 32'd0);

    applyStimulus(24'h8000FF, 24'h400000, lat);
    checkOutput("post_rst_lat", lat, 32'd18);
    checkOutput("post_rst_o", {8'd0, o}, 32'h00C00000);
    handoff();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule
